// File: rtl/seg7_scan_reader.sv
// Monitors a multiplexed 4-digit common-anode seven-segment bus and recovers the displayed
// 16-bit hex value once the same clean frame has been seen on enough consecutive scans.
module seg7_scan_reader #(
    parameter int unsigned SETTLE       = 4,
    parameter int unsigned STABLE_SCANS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        err
);
    localparam logic [7:0] SettleCnt = 8'(SETTLE);
    localparam logic [3:0] StableCnt = 4'(STABLE_SCANS);

    logic [6:0]  seg_q, seg_prev_q;
    logic [3:0]  dig_q, dig_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] prev_frame_q, prev_frame_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  mask_q, mask_d;
    logic        bad_q, bad_d;
    logic [3:0]  match_q, match_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        sel_legal;
    logic [1:0]  sel_idx;
    logic        capture;
    logic [3:0]  nibble;
    logic        nib_bad;

    always_comb begin
        sel_legal = 1'b1;
        sel_idx   = 2'd0;
        case (dig_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        nib_bad = 1'b0;
        nibble  = 4'h0;
        case (seg_q)
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
            default: nib_bad = 1'b1;
        endcase
    end

    // Dwell deglitch: one capture when the count first reaches SETTLE, then hold there.
    always_comb begin
        if (!sel_legal) begin
            cnt_d = 8'd0;
        end else if ({dig_q, seg_q} != {dig_prev_q, seg_prev_q}) begin
            cnt_d = 8'd1;
        end else if (cnt_q != SettleCnt) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        capture = sel_legal && (cnt_d == SettleCnt) && (cnt_q != SettleCnt);
    end

    always_comb begin
        frame_d      = frame_q;
        mask_d       = mask_q;
        bad_d        = bad_q;
        match_d      = match_q;
        prev_frame_d = prev_frame_q;
        value_d      = value_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;

        // Evaluation sees the pre-edge frame; a same-edge capture starts the next frame.
        if (mask_q == 4'hF) begin
            mask_d = 4'h0;
            bad_d  = 1'b0;
            if (bad_q) begin
                err_d   = 1'b1;
                match_d = 4'd0;
            end else if (frame_q == prev_frame_q) begin
                if (match_q != StableCnt) begin
                    match_d = match_q + 4'd1;
                    if (match_q + 4'd1 == StableCnt) begin
                        value_d = frame_q;
                        valid_d = 1'b1;
                    end
                end
            end else begin
                match_d      = 4'd1;
                prev_frame_d = frame_q;
                if (StableCnt == 4'd1) begin
                    value_d = frame_q;
                    valid_d = 1'b1;
                end
            end
        end

        if (capture) begin
            frame_d[{sel_idx, 2'b00} +: 4] = nibble;
            mask_d[sel_idx]                = 1'b1;
            bad_d                          = bad_d | nib_bad;
        end
    end

    // Input registers reset to an illegal select so a dwell in progress must re-settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= 7'h7F;
            dig_q        <= 4'hF;
            seg_prev_q   <= 7'h7F;
            dig_prev_q   <= 4'hF;
            cnt_q        <= 8'd0;
            frame_q      <= 16'h0000;
            mask_q       <= 4'h0;
            bad_q        <= 1'b0;
            match_q      <= 4'd0;
            prev_frame_q <= 16'h0000;
            value_q      <= 16'h0000;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            seg_q        <= seg_n;
            dig_q        <= dig_n;
            seg_prev_q   <= seg_q;
            dig_prev_q   <= dig_q;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            mask_q       <= mask_d;
            bad_q        <= bad_d;
            match_q      <= match_d;
            prev_frame_q <= prev_frame_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign err         = err_q;

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

- Recovers the hex value shown on a multiplexed 4-digit, common-anode seven-segment display bus.
- Samples the segment lines and digit enables, and deglitches each digit dwell.
- Converts each active-low segment pattern back to its 4-bit hex nibble.
- Publishes a 16-bit value once the same complete frame has been seen on consecutive scans.
- Sits on the display side of the design as the read-back/monitor counterpart of the hex-to-segment drivers, and feeds self-check and logging logic.

## Interface
- SETTLE, default 4: consecutive identical samples (same digit select, same segments) required before a digit is captured; legal range 2..255.
- STABLE_SCANS, default 2: consecutive identical, error-free frames required before a value is published; legal range 1..15.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_n  input  7  active-low segments, bit0=a … bit6=g (0 = lit).
- dig_n  input  4  active-low digit enables; dig_n[3] is the most significant digit.
- value  output  16  last published value; digit k maps to value[4k+3:4k].
- value_valid  output  1  one-cycle pulse when value updates.
- err  output  1  one-cycle pulse when a frame is rejected because it contains an undecodable pattern.

## Operation
- **Input register.** seg_n and dig_n are registered once. All further logic uses the registered copies.
- **Legal select.** Exactly one bit of dig_n is 0. Any other dig_n clears the settle counter, and no capture is made.
- **Settle counter.**
  - Increments while the registered {dig_n, seg_n} equals the previous registered sample and the select is legal.
  - Reloads to 1 on any change to a legal select.
  - The digit is captured when the count reaches SETTLE. Only one capture is made per dwell.
  - The counter saturates until the inputs change, so a long dwell never re-captures.
- **Decode table** (seg_n hex → nibble):
  - 40→0, 79→1, 24→2, 30→3
  - 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→B
  - 46→C, 21→D, 06→E, 0E→F
  - All other patterns, including blank 7F, are bad.
- **Frame capture.**
  - Each capture writes the nibble into frame slot k, sets captured_mask[k], and ORs the bad flag into frame_bad.
  - A re-capture of an already-captured slot overwrites it.
- **Frame complete** (captured_mask = 1111), evaluated on the edge after the completing capture:
  - If frame_bad: pulse err, clear match_cnt, leave prev_frame unchanged.
  - Else if the frame equals prev_frame: match_cnt increments, saturating at STABLE_SCANS.
  - Else: match_cnt = 1 and prev_frame = frame.
  - Publish when match_cnt becomes equal to STABLE_SCANS on this edge (a transition, not a hold): value ← frame, value_valid pulses.
  - captured_mask and frame_bad always clear on this edge.
- **Repeats.** A stable display publishes once. Further identical frames keep match_cnt saturated and produce no pulse. A changed display must again reach STABLE_SCANS matches before it is published.
- **STABLE_SCANS = 1.** Every error-free frame that differs from prev_frame publishes immediately.

## Timing
- **Reset values.** After a rst edge:
  - value = 0000, value_valid = 0, err = 0.
  - captured_mask = 0, frame_bad = 0, match_cnt = 0.
  - settle counter = 0, prev_frame = 0000.
- **Reset mid-frame or mid-dwell.** Partial captures are discarded, and the dwell in progress must re-settle from count 0.
- **Capture latency.** A digit first present at the pins before edge t is captured at edge t+SETTLE.
- **Publish latency.** value and value_valid update at edge t+SETTLE+1, where t belongs to the completing digit's dwell.
- **Shortest dwell.** A dwell shorter than SETTLE identical samples is never captured. Its slot keeps its earlier content or stays uncaptured.
- **Simultaneous events.** When a capture and frame evaluation fall on the same edge, evaluation uses the mask and frame from before that edge. The new capture lands in the cleared mask and starts the next frame.
- **Output widths.** value_valid and err are never high together, and each lasts exactly one cycle.
- **Scan order.** Digits may arrive in any order and need not be unique per scan. Only mask completion matters.

## Test plan
- **Reset state.** Hold rst for 3 cycles with arbitrary inputs → value=0000, value_valid=0 and err=0 throughout, and no publish before 4 captures.
- **Stable display.** SETTLE=4, STABLE_SCANS=2; scan digits 3..0 with seg_n 79, 08, 30, 0E at 8 cycles each, for 3 scans → exactly one value_valid, value=1A3F, asserted at edge t+5 of the final digit of scan 2. Scan 3 produces no pulse.
- **Deglitch.** Insert a 3-cycle dwell with dig_n=0111, seg_n=40 mid-scan, plus a 2-cycle dig_n=0011 overlap → no capture from either; result identical to the stable-display scenario.
- **Bad pattern.** Scan 2 carries seg_n=7F on digit 1 → err pulses once at scan-2 completion and nothing is published. The next two clean scans then publish 1A3F.
- **Value change.** After 1A3F is published, switch to 79, 08, 30, 40 → after two clean scans value=1A30 with one pulse. A single odd frame between identical ones resets the match count.
- **Mid-frame reset.** Assert rst after 2 captures → the next two full scans are required before publishing, and value reads 0000 until then.
